// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit saturating-counter branch predictor with an
// in-order resolve queue and a one-cycle mispredict/flush recovery FSM.
// Optional feature: define BP_GSHARE_EN to XOR the table index with a
// global history register (gshare); undefined gives a pure bimodal index.
module branch_pred_ctrl #(
  parameter int IDX_W   = 4,
  parameter int Q_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic                       fetch_is_br,
  input  logic [15:0]                fetch_pc,
  output logic                       pred_taken,
  output logic                       fetch_stall,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       mispredict,
  output logic                       flush,
  output logic [$clog2(Q_DEPTH):0]   q_count
);

  localparam int PW      = $clog2(Q_DEPTH);
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t state, state_nxt;

  logic [1:0]       ctr    [ENTRIES];
  logic [IDX_W-1:0] q_idx  [Q_DEPTH];
  logic             q_pred [Q_DEPTH];
  logic [PW-1:0]    head, tail;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] pop_idx;
  logic             push, pop, mis;

  // PC bits outside the index field do not affect prediction
  logic unused_pc;
  assign unused_pc = ^{fetch_pc[15:IDX_W+1], fetch_pc[0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // gshare lookup index: PC index folded with resolved-branch history
  always_comb begin
    lookup_idx = fetch_pc[IDX_W:1] ^ ghr;
  end

  // Non-speculative history: shifted only on accepted pops, kept across flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (pop) begin
      ghr <= {ghr[IDX_W-2:0], res_taken};
    end
  end
`else
  // Bimodal lookup index straight from the halfword-aligned PC
  always_comb begin
    lookup_idx = fetch_pc[IDX_W:1];
  end
`endif

  // Lookup, queue handshakes and pop result
  always_comb begin
    pred_taken = ctr[lookup_idx][1];
    push       = fetch_valid & fetch_is_br & ~fetch_stall;
    pop        = res_valid & (q_count != '0) & (state == RUN);
    pop_idx    = q_idx[head];
    mis        = pop & (res_taken != q_pred[head]);
  end

  // Counter table: reset to weakly-not-taken, saturating training on pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (pop) begin
      if (res_taken && ctr[pop_idx] != 2'b11) begin
        ctr[pop_idx] <= ctr[pop_idx] + 2'b01;
      end else if (!res_taken && ctr[pop_idx] != 2'b00) begin
        ctr[pop_idx] <= ctr[pop_idx] - 2'b01;
      end
    end
  end

  // Queue payload storage; no reset needed since q_count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= lookup_idx;
      q_pred[tail] <= pred_taken;
    end
  end

  // Queue pointers and occupancy; a mispredicting pop wipes everything,
  // including a push arriving in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else if (mis) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and recovery outputs
  always_comb begin
    state_nxt   = state;
    mispredict  = 1'b0;
    flush       = 1'b0;
    fetch_stall = (q_count == ($clog2(Q_DEPTH)+1)'(Q_DEPTH));
    case (state)
      RUN: begin
        if (mis) state_nxt = RECOVER;
      end
      RECOVER: begin
        mispredict  = 1'b1;
        flush       = 1'b1;
        fetch_stall = 1'b1;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Testbench for branch_pred_ctrl: table-driven vectors with a scoreboard
// queue of post-edge expectations, plus a hand-written async-reset sequence.
// Build with BP_GSHARE_EN defined to exercise the gshare vector table.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_is_br;
  logic [15:0] fetch_pc;
  logic        pred_taken, fetch_stall;
  logic        res_valid, res_taken;
  logic        mispredict, flush;
  logic [2:0]  q_count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  typedef struct {
    logic        fv;
    logic        br;
    logic [15:0] pc;
    logic        rv;
    logic        rt;
    logic        ep;   // expected pred_taken before the edge
    logic        es;   // expected fetch_stall before the edge
    logic [2:0]  eq;   // expected q_count after the edge
    logic        em;   // expected mispredict/flush after the edge
  } vec_t;

  typedef struct {
    logic [2:0] eq;
    logic       em;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];

  branch_pred_ctrl #(.IDX_W(4), .Q_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_is_br (fetch_is_br),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .fetch_stall (fetch_stall),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .mispredict  (mispredict),
    .flush       (flush),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic fv, input logic br, input logic [15:0] pc,
                     input logic rv, input logic rt, input logic ep,
                     input logic es, input logic [2:0] eq, input logic em);
    vec_t v;
    v.fv = fv; v.br = br; v.pc = pc; v.rv = rv; v.rt = rt;
    v.ep = ep; v.es = es; v.eq = eq; v.em = em;
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive, check combinational outputs, queue the
  // post-edge expectation, then compare it one half-cycle after the rise
  task automatic step(input vec_t v, input int unsigned n);
    post_t e, got;
    fetch_valid = v.fv; fetch_is_br = v.br; fetch_pc = v.pc;
    res_valid   = v.rv; res_taken   = v.rt;
    #1;
    chk($sformatf("v%0d pred_taken", n), 32'(pred_taken), 32'(v.ep));
    chk($sformatf("v%0d fetch_stall", n), 32'(fetch_stall), 32'(v.es));
    e.eq = v.eq; e.em = v.em;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    chk($sformatf("v%0d q_count", n), 32'(q_count), 32'(got.eq));
    chk($sformatf("v%0d mispredict", n), 32'(mispredict), 32'(got.em));
    chk($sformatf("v%0d flush", n), 32'(flush), 32'(got.em));
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    fetch_valid = 1'b0; fetch_is_br = 1'b0; fetch_pc = 16'h0010;
    res_valid = 1'b0; res_taken = 1'b0;

`ifndef BP_GSHARE_EN
    //   fv br pc       rv rt  ep es eq em
    add(1, 1, 16'h0010, 0, 0,  0, 0, 1, 0); // first branch, WNT predicts 0
    add(0, 0, 16'h0010, 1, 1,  0, 0, 0, 1); // resolve taken: mispredict
    add(0, 0, 16'h0010, 0, 0,  1, 1, 0, 0); // RECOVER, counter now 10
    add(1, 1, 16'h0010, 0, 0,  1, 0, 1, 0);
    add(1, 1, 16'h0010, 1, 1,  1, 0, 1, 0); // push+pop correct -> 11
    add(1, 1, 16'h0010, 1, 1,  1, 0, 1, 0); // saturates at 11
    add(1, 1, 16'h0010, 1, 0,  1, 0, 0, 1); // not taken: 11->10, push dropped
    add(0, 0, 16'h0010, 0, 0,  1, 1, 0, 0); // still predicts taken
    add(1, 1, 16'h0010, 0, 0,  1, 0, 1, 0);
    add(0, 0, 16'h0010, 1, 0,  1, 0, 0, 1); // pre-write value seen; 10->01
    add(0, 0, 16'h0010, 0, 0,  0, 1, 0, 0); // now predicts not taken
    add(1, 1, 16'h0010, 0, 0,  0, 0, 1, 0); // fill the queue
    add(1, 1, 16'h0002, 0, 0,  0, 0, 2, 0);
    add(1, 1, 16'h0020, 0, 0,  0, 0, 3, 0);
    add(1, 1, 16'h0004, 0, 0,  0, 0, 4, 0);
    add(1, 1, 16'h0010, 0, 0,  0, 1, 4, 0); // full: fifth push refused
    add(1, 1, 16'h0010, 1, 0,  0, 1, 3, 0); // no pop bypass while full
    add(0, 0, 16'h0010, 0, 0,  0, 0, 3, 0); // stall drops
    add(1, 1, 16'h0006, 1, 1,  0, 0, 0, 1); // head mispredicts + push
    add(0, 0, 16'h0002, 1, 0,  1, 1, 0, 0); // res in RECOVER ignored
    add(0, 0, 16'h0006, 1, 0,  0, 0, 0, 0); // res with empty queue ignored
    add(0, 0, 16'h0002, 0, 0,  1, 0, 0, 0); // counter untouched by both
    add(1, 1, 16'h0010, 0, 0,  0, 0, 1, 0);
    add(1, 1, 16'h0012, 0, 0,  0, 0, 2, 0);
`else
    //   fv br pc       rv rt  ep es eq em
    add(1, 1, 16'h0020, 0, 0,  0, 0, 1, 0); // ghr 0000, idx 0
    add(0, 0, 16'h0020, 1, 1,  0, 0, 0, 1); // T: ctr0=10, ghr 0001
    add(0, 0, 16'h0020, 0, 0,  0, 1, 0, 0); // idx 1
    add(1, 1, 16'h0020, 0, 0,  0, 0, 1, 0);
    add(0, 0, 16'h0020, 1, 0,  0, 0, 0, 0); // N: ctr1=00, ghr 0010
    add(1, 1, 16'h0020, 0, 0,  0, 0, 1, 0); // idx 2
    add(0, 0, 16'h0020, 1, 1,  0, 0, 0, 1); // T: ctr2=10, ghr 0101
    add(0, 0, 16'h0020, 0, 0,  0, 1, 0, 0);
    add(1, 1, 16'h0020, 0, 0,  0, 0, 1, 0); // idx 5
    add(0, 0, 16'h0020, 1, 1,  0, 0, 0, 1); // T: ctr5=10, ghr 1011
    add(0, 0, 16'h001C, 0, 0,  1, 1, 0, 0); // 14^11 = 5 -> taken
    add(0, 0, 16'h0000, 0, 0,  0, 0, 0, 0); // 0^11 = 11, bimodal would be 1
    add(0, 0, 16'h0016, 0, 0,  1, 0, 0, 0); // 11^11 = 0 -> ctr0 taken
    add(1, 1, 16'h0002, 0, 0,  0, 0, 1, 0); // PC 0x0002 -> idx 10, not 1
    add(0, 0, 16'h0002, 1, 1,  0, 0, 0, 1); // T: ctr10=10, ghr 0111
    add(0, 0, 16'h001A, 0, 0,  1, 1, 0, 0); // 13^7 = 10 -> taken
    add(0, 0, 16'h0002, 0, 0,  0, 0, 0, 0); // 1^7 = 6, ctr1 still 00
    add(1, 1, 16'h0010, 0, 0,  0, 0, 1, 0);
    add(1, 1, 16'h0012, 0, 0,  0, 0, 2, 0);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset fetch_stall", 32'(fetch_stall), 32'd0);
    chk("reset mispredict", 32'(mispredict), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset q_count", 32'(q_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Asynchronous reset with two branches in flight
    fetch_valid = 1'b0; fetch_is_br = 1'b0; res_valid = 1'b0;
    fetch_pc = 16'h0002;
    #2 rst = 1'b0;
    #1;
    chk("async rst q_count", 32'(q_count), 32'd0);
    chk("async rst pred_taken", 32'(pred_taken), 32'd0);
    chk("async rst fetch_stall", 32'(fetch_stall), 32'd0);
    chk("async rst mispredict", 32'(mispredict), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v.fv = 1; v.br = 1; v.pc = 16'h0010; v.rv = 0; v.rt = 0;
    v.ep = 0; v.es = 0; v.eq = 3'd1; v.em = 0;
    step(v, 999);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Dynamic branch prediction controller for the fetch/execute pipeline. It owns a table of 2-bit saturating counters indexed from the fetch PC and returns a same-cycle taken/not-taken prediction for branch instructions. It tracks every in-flight prediction in an in-order resolve queue, updates the counters when execute resolves each branch, and raises a one-cycle mispredict/flush pulse that drives pipeline recovery.

## Interface
- `IDX_W`, 4, counter-table index width; the table has 2^IDX_W entries
- `Q_DEPTH`, 4, resolve-queue depth; must be a power of 2, minimum 2
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset; asserted at 0
- `fetch_valid`  in  1  the fetch stage holds a valid instruction
- `fetch_is_br`  in  1  the fetched instruction is a conditional branch
- `fetch_pc`  in  16  fetch PC; halfword aligned
- `pred_taken`  out  1  predicted direction for `fetch_pc`
- `fetch_stall`  out  1  fetch must hold; the branch is not accepted
- `res_valid`  in  1  execute is resolving the oldest in-flight branch
- `res_taken`  in  1  actual direction of that branch
- `mispredict`  out  1  one-cycle pulse: the resolved direction differed from the prediction
- `flush`  out  1  one-cycle pulse: wrong-path instructions must be squashed; equal to `mispredict`
- `q_count`  out  log2(Q_DEPTH)+1  number of in-flight branches

## Operation
- Index: `idx = fetch_pc[IDX_W:1]`. With the gshare feature enabled, the index is XORed with the GHR (see Configuration).
- Each counter is 2 bits with encoding 00 SNT, 01 WNT, 10 WT, 11 ST. The prediction is the counter MSB.
- Training is saturating: taken increments toward 11, not-taken decrements toward 00.
- Push: `fetch_valid & fetch_is_br & !fetch_stall` enqueues {idx, pred}.
- Pop: `res_valid` with a non-empty queue pops the head entry.
  - The counter at the head's idx is trained with `res_taken`.
  - The result compares `res_taken` against the head's pred.
  - `res_valid` with an empty queue is ignored: no table change and no pulse.
- Mispredict on a pop: the whole queue is cleared at that edge, because all younger entries are on the wrong path. A push in the same cycle is also dropped.
- Correct prediction: head pop only. A simultaneous push and pop leaves `q_count` unchanged.
- Controller FSM:
  - States are RUN and RECOVER.
  - RUN → RECOVER on a mispredicting pop.
  - RECOVER → RUN unconditionally after one cycle.
  - In RECOVER: `mispredict = flush = 1` and `fetch_stall = 1`. Any `res_valid` is ignored, since it cannot be legal with an empty queue.
- Same-index collision: a lookup in the same cycle as a training write returns the pre-write value. The new value is visible the next cycle.
- Reset (any time, mid-operation included):
  - All counters go to 01 (WNT) and the queue empties.
  - The FSM goes to RUN and the GHR clears.
  - Outputs: `pred_taken = 0` (01 predicts not taken), `fetch_stall = 0`, `mispredict = flush = 0`, `q_count = 0`.

## Timing
- `pred_taken` is combinational from `fetch_pc` and the table, with zero latency.
- `fetch_stall` is combinational: high in RECOVER, or when `q_count == Q_DEPTH`. There is no same-cycle pop bypass when the queue is full.
- `mispredict`/`flush` are registered: high for exactly the one cycle after the mispredicting `res_valid` edge.
- Counter update and GHR update take effect at the edge that samples `res_valid`.
- Head/tail pointers are log2(Q_DEPTH) bits and wrap modulo Q_DEPTH. Full and empty are determined from `q_count`.

## Configuration
- `BP_GSHARE_EN` defined:
  - The block keeps an IDX_W-bit global history register (GHR). It shifts in `res_taken` on each non-ignored pop, non-speculatively.
  - Lookup index is `fetch_pc[IDX_W:1] ^ GHR`. Each queue entry stores that full index, so training hits the same counter that produced the prediction.
  - The GHR is not cleared on flush.
- Undefined: no GHR and a pure bimodal index.

## Test plan
- Reset, then a branch at PC 0x0010 → `pred_taken = 0`, `q_count = 1`. Resolve taken → `mispredict` pulses 1 cycle; the counter goes to 10; the next lookup of 0x0010 gives `pred_taken = 1`.
- Resolve PC 0x0010 taken 3 times, then not-taken once → counter 11 then 10, and the prediction stays 1. A second not-taken gives 01 → prediction 0.
- Push 4 branches with no resolve → `q_count = 4` and `fetch_stall = 1`, and a fifth push is not accepted. Resolve one correctly → `q_count = 3` and the stall drops.
- 3 in flight, the head mispredicts while fetch pushes in the same cycle → `q_count = 0` the next cycle; `flush`/`mispredict` are high for exactly 1 cycle with `fetch_stall = 1`; then RUN.
- `res_valid` with an empty queue → no pulse and the table is unchanged. Assert `rst = 0` mid-stream with 2 in flight → `q_count` reads 0 immediately, without waiting for a clock edge.
- With `BP_GSHARE_EN`: PC 0x0002 after history T,N,T,T trains a different counter than with zeroed history → predictions diverge as specified by the XOR index.
